deser_queue_top: RTL and testbench



---
 rtl/deser_queue_pkg.sv | 6 +
 rtl/byte_queue.sv | 44 ++++
 rtl/deser_queue_top.sv | 51 +++++
 tb/tb_deser_queue_top.sv | 119 +++++++++++
 4 files changed

// File: rtl/deser_queue_pkg.sv
// deser_queue_pkg: shared widths, default queue depth and the byte type
package deser_queue_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 8;
  typedef logic [DATA_W-1:0] byte_t;
endpackage

// File: rtl/byte_queue.sv
// byte_queue: circular byte FIFO with a registered pop output
module byte_queue
  import deser_queue_pkg::*;
#(
  parameter int DEPTH = deser_queue_pkg::DEPTH
) (
  input  logic  clk,
  input  logic  queue_rst,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  byte_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == CNT_FULL;
  assign empty = r_cnt == '0;
  assign w_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full queue still accepts the push
  assign w_push = push & (~full | w_pop) & queue_rst;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!queue_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
      dout <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        dout <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/deser_queue_top.sv
// deser_queue_top: MSB-first serial byte capture feeding a byte FIFO, independent active-low resets
module deser_queue_top #(
  parameter int DEPTH = deser_queue_pkg::DEPTH,
  parameter int DATA_W = deser_queue_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              deserializer_rst,
  input  logic              queue_rst,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] queue_data_out
);
  import deser_queue_pkg::*;
  logic r_wr_q, r_deq_q, r_byte_valid;
  logic [2:0] r_bit_cnt;
  byte_t r_shift, r_byte;
  logic w_wr_evt, w_deq_evt, w_push, w_pop, w_full, w_empty;
  assign w_wr_evt = write_in & ~r_wr_q;
  assign w_deq_evt = dequeue_in & ~r_deq_q;
  assign w_pop = w_deq_evt & ~w_empty;
  assign w_push = r_byte_valid & (~w_full | w_pop);
  always_ff @(posedge clk) begin
    if (!deserializer_rst) begin
      r_wr_q <= 1'b1;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_wr_q <= write_in;
      r_byte_valid <= w_wr_evt & (r_bit_cnt == 3'd7);
      if (w_wr_evt) begin
        r_shift <= {r_shift[6:0], data_in};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_wr_evt && r_bit_cnt == 3'd7) r_byte <= {r_shift[6:0], data_in};
    end
  end
  always_ff @(posedge clk)
    r_deq_q <= queue_rst ? dequeue_in : 1'b1;
  byte_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .queue_rst(queue_rst),
    .push(w_push),
    .din(r_byte),
    .pop(w_pop),
    .dout(queue_data_out),
    .full(w_full),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_deser_queue_top.sv
// tb_deser_queue_top: directed stimulus with a scoreboard queue checked by an independent dequeue monitor
module tb_deser_queue_top;
  logic clk = 0;
  logic deserializer_rst = 0, queue_rst = 0, data_in = 0, write_in = 0, dequeue_in = 0;
  logic [7:0] queue_data_out;
  logic [7:0] exp_q [$];
  int n_total = 0, n_pass = 0;
  always #5 clk = ~clk;
  deser_queue_top #(.DEPTH(8), .DATA_W(8)) dut (
    .clk(clk),
    .deserializer_rst(deserializer_rst),
    .queue_rst(queue_rst),
    .data_in(data_in),
    .write_in(write_in),
    .dequeue_in(dequeue_in),
    .queue_data_out(queue_data_out)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask
  task automatic send_bit(input logic b, input int width);
    @(negedge clk);
    data_in = b;
    write_in = 1;
    repeat (width) @(negedge clk);
    write_in = 0;
    @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] v, input int width);
    for (int i = 7; i >= 0; i--) send_bit(v[i], width);
  endtask
  task automatic deq(input logic [7:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    dequeue_in = 1;
    @(negedge clk);
    dequeue_in = 0;
    @(negedge clk);
  endtask
  initial begin
    logic deq_hist = 1;
    logic ev;
    forever begin
      @(posedge clk);
      ev = dequeue_in & ~deq_hist & queue_rst;
      deq_hist = queue_rst ? dequeue_in : 1'b1;
      if (ev) begin
        #1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL deq: got %02h with no expected value queued", queue_data_out);
        end else chk("deq", queue_data_out, exp_q.pop_front());
      end
    end
  end
  initial begin
    int budget;
    repeat (3) @(negedge clk);
    deserializer_rst = 1;
    queue_rst = 1;
    @(negedge clk);
    chk("reset_out", queue_data_out, 8'h00);
    send_byte(8'hB2, 10);
    chk("before_deq", queue_data_out, 8'h00);
    deq(8'hB2);
    send_byte(8'h3C, 1);
    send_byte(8'hA5, 2);
    deq(8'h3C);
    deq(8'hA5);
    deq(8'hA5);
    for (int v = 1; v <= 9; v++) send_byte(8'(v), 1);
    for (int v = 1; v <= 8; v++) deq(8'(v));
    deq(8'h08);
    send_byte(8'h77, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    deserializer_rst = 0;
    repeat (2) @(negedge clk);
    deserializer_rst = 1;
    send_byte(8'hF0, 1);
    deq(8'h77);
    deq(8'hF0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    queue_rst = 0;
    repeat (2) @(negedge clk);
    queue_rst = 1;
    @(negedge clk);
    chk("qrst_out", queue_data_out, 8'h00);
    deq(8'h00);
    send_byte(8'h5A, 1);
    send_bit(1'b1, 20);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1);
    @(negedge clk);
    data_in = 1;
    write_in = 1;
    @(negedge clk);
    write_in = 0;
    exp_q.push_back(8'h5A);
    dequeue_in = 1;
    @(negedge clk);
    dequeue_in = 0;
    @(negedge clk);
    deq(8'h81);
    deq(8'h81);
    budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected values never checked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
